e_m_pipe_reg: RTL and testbench

- Pipeline register between the Execute stage and the Memory stage.
- Each cycle it selects the E-stage result: the ALU result, or the multiply/divide unit's HI or LO output for mfhi/mflo.
- It detects the multiply/divide structural hazard from the unit's Busy flag, and it inserts a bubble into M while raising a stall request upstream.
- It keeps a saturating counter of stall cycles caused by the multiply/divide unit, for performance analysis.

---
 rtl/e_m_pipe_reg_pkg.sv | 27 ++
 rtl/e_m_pipe_reg_md_hazard_det.sv | 29 ++
 rtl/e_m_pipe_reg.sv | 104 ++++++++++
 tb/tb_e_m_pipe_reg.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/e_m_pipe_reg_pkg.sv
// ---------------------------------------------------------------------------
// e_m_pipe_reg_pkg
// Shared definitions for the E/M pipeline boundary: multiply/divide op codes
// (also used by the multiply/divide unit and the decoder), memory-op code
// width and default datapath widths.
// ---------------------------------------------------------------------------
package e_m_pipe_reg_pkg;

    localparam int DW_DEF    = 32;
    localparam int RW_DEF    = 5;
    localparam int MEM_CTL_W = 4;
    localparam int MD_TYPE_W = 4;

    typedef enum logic [MD_TYPE_W-1:0] {
        MD_NONE  = 4'd0,
        MD_DIV   = 4'd1,
        MD_DIVU  = 4'd2,
        MD_MULT  = 4'd3,
        MD_MULTU = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MSUB  = 4'd9
    } md_type_e;

endpackage

// File: rtl/e_m_pipe_reg_md_hazard_det.sv
// ---------------------------------------------------------------------------
// md_hazard_det
// Combinational multiply/divide structural-hazard detector.
// Ports:
//   reset      in  active-low reset; forces stall_req low while asserted
//   e_valid    in  E stage holds a real instruction
//   e_md_type  in  multiply/divide op code of the E instruction
//   md_busy    in  multiply/divide unit is computing
//   m_hold     in  M stage cannot accept new data
//   md_haz     out E instruction must wait for the unit
//   stall_req  out upstream stages must freeze
// ---------------------------------------------------------------------------
module md_hazard_det
    import e_m_pipe_reg_pkg::*;
(
    input  logic                 reset,
    input  logic                 e_valid,
    input  logic [MD_TYPE_W-1:0] e_md_type,
    input  logic                 md_busy,
    input  logic                 m_hold,
    output logic                 md_haz,
    output logic                 stall_req
);

    // Any md op waits on Busy; the issuing op sees Busy low in its own cycle.
    assign md_haz    = e_valid & md_busy & (e_md_type != MD_NONE);
    assign stall_req = reset & (md_haz | m_hold);

endmodule

// File: rtl/e_m_pipe_reg.sv
// ---------------------------------------------------------------------------
// e_m_pipe_reg
// Execute -> Memory pipeline register. Selects the E result (ALU, HI or LO),
// inserts bubbles on flush or multiply/divide hazard, honours downstream
// hold, and counts hazard stall cycles with a saturating counter.
// Ports:
//   clk, reset               clock, synchronous active-low reset
//   e_valid .. e_md_type     E-stage instruction fields
//   md_hi, md_lo, md_busy    multiply/divide unit outputs
//   e_flush                  kill the E instruction
//   m_hold                   M stage cannot accept
//   stall_req                combinational freeze request upstream
//   m_valid .. m_mem_ctl     registered M-stage fields
//   md_stall_cnt             saturating count of md hazard cycles
// ---------------------------------------------------------------------------
module e_m_pipe_reg
    import e_m_pipe_reg_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF,
    parameter int CW = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 e_valid,
    input  logic [DW-1:0]        e_pc,
    input  logic [DW-1:0]        e_alu_res,
    input  logic [DW-1:0]        e_st_data,
    input  logic [RW-1:0]        e_wr_addr,
    input  logic [MEM_CTL_W-1:0] e_mem_ctl,
    input  logic [MD_TYPE_W-1:0] e_md_type,
    input  logic [DW-1:0]        md_hi,
    input  logic [DW-1:0]        md_lo,
    input  logic                 md_busy,
    input  logic                 e_flush,
    input  logic                 m_hold,
    output logic                 stall_req,
    output logic                 m_valid,
    output logic [DW-1:0]        m_pc,
    output logic [DW-1:0]        m_res,
    output logic [DW-1:0]        m_st_data,
    output logic [RW-1:0]        m_wr_addr,
    output logic [MEM_CTL_W-1:0] m_mem_ctl,
    output logic [CW-1:0]        md_stall_cnt
);

    logic          md_haz;
    logic [DW-1:0] e_res;

    md_hazard_det u_haz (
        .reset     (reset),
        .e_valid   (e_valid),
        .e_md_type (e_md_type),
        .md_busy   (md_busy),
        .m_hold    (m_hold),
        .md_haz    (md_haz),
        .stall_req (stall_req)
    );

    always_comb begin
        e_res = e_alu_res;
        case (e_md_type)
            MD_MFHI: e_res = md_hi;
            MD_MFLO: e_res = md_lo;
            default: e_res = e_alu_res;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            m_valid      <= 1'b0;
            m_pc         <= '0;
            m_res        <= '0;
            m_st_data    <= '0;
            m_wr_addr    <= '0;
            m_mem_ctl    <= '0;
            md_stall_cnt <= '0;
        end else begin
            // Hold freezes the counter too: those cycles are charged to M.
            if (md_haz && !m_hold && (md_stall_cnt != '1))
                md_stall_cnt <= md_stall_cnt + CW'(1);

            if (!m_hold) begin
                if (e_flush || md_haz) begin
                    // Zero wr_addr so M/W forwarding never matches a bubble.
                    m_valid   <= 1'b0;
                    m_pc      <= '0;
                    m_res     <= '0;
                    m_st_data <= '0;
                    m_wr_addr <= '0;
                    m_mem_ctl <= '0;
                end else begin
                    m_valid   <= e_valid;
                    m_pc      <= e_pc;
                    m_res     <= e_res;
                    m_st_data <= e_st_data;
                    m_wr_addr <= e_wr_addr;
                    m_mem_ctl <= e_mem_ctl;
                end
            end
        end
    end

endmodule

// File: tb/tb_e_m_pipe_reg.sv
module tb_e_m_pipe_reg;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          e_valid;
    logic [DW-1:0] e_pc, e_alu_res, e_st_data;
    logic [RW-1:0] e_wr_addr;
    logic [3:0]    e_mem_ctl, e_md_type;
    logic [DW-1:0] md_hi, md_lo;
    logic          md_busy, e_flush, m_hold;
    logic          stall_req, m_valid;
    logic [DW-1:0] m_pc, m_res, m_st_data;
    logic [RW-1:0] m_wr_addr;
    logic [3:0]    m_mem_ctl;
    logic [CW-1:0] md_stall_cnt;

    e_m_pipe_reg #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .reset(reset), .e_valid(e_valid), .e_pc(e_pc),
        .e_alu_res(e_alu_res), .e_st_data(e_st_data), .e_wr_addr(e_wr_addr),
        .e_mem_ctl(e_mem_ctl), .e_md_type(e_md_type), .md_hi(md_hi),
        .md_lo(md_lo), .md_busy(md_busy), .e_flush(e_flush), .m_hold(m_hold),
        .stall_req(stall_req), .m_valid(m_valid), .m_pc(m_pc), .m_res(m_res),
        .m_st_data(m_st_data), .m_wr_addr(m_wr_addr), .m_mem_ctl(m_mem_ctl),
        .md_stall_cnt(md_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: the M stage as a record, updated from the rules of
    // reset > hold > (flush | hazard) > load, with a saturating integer count.
    bit          r_valid;
    logic [31:0] r_pc, r_res, r_st;
    logic [4:0]  r_wr;
    logic [3:0]  r_mem;
    int          r_cnt;

    function automatic bit ref_haz();
        return e_valid && md_busy && (e_md_type != 4'd0);
    endfunction

    function automatic bit ref_stall();
        return reset && (ref_haz() || m_hold);
    endfunction

    task automatic ref_edge();
        if (!reset) begin
            r_valid = 0; r_pc = 0; r_res = 0; r_st = 0; r_wr = 0; r_mem = 0; r_cnt = 0;
        end else begin
            if (ref_haz() && !m_hold && r_cnt < CNT_MAX) r_cnt = r_cnt + 1;
            if (!m_hold) begin
                if (e_flush || ref_haz()) begin
                    r_valid = 0; r_pc = 0; r_res = 0; r_st = 0; r_wr = 0; r_mem = 0;
                end else begin
                    r_valid = e_valid;
                    r_pc    = e_pc;
                    r_st    = e_st_data;
                    r_wr    = e_wr_addr;
                    r_mem   = e_mem_ctl;
                    r_res   = (e_md_type == 4'd5) ? md_hi :
                              (e_md_type == 4'd6) ? md_lo : e_alu_res;
                end
            end
        end
    endtask

    // One clock: check combinational stall_req, advance model, check M fields.
    task automatic cycle();
        #1;
        chk("stall_req", {63'd0, stall_req}, {63'd0, ref_stall()});
        ref_edge();
        @(posedge clk);
        #1;
        chk("m_valid", {63'd0, m_valid}, {63'd0, r_valid});
        chk("m_pc", {32'd0, m_pc}, {32'd0, r_pc});
        chk("m_res", {32'd0, m_res}, {32'd0, r_res});
        chk("m_st_data", {32'd0, m_st_data}, {32'd0, r_st});
        chk("m_wr_addr", {59'd0, m_wr_addr}, {59'd0, r_wr});
        chk("m_mem_ctl", {60'd0, m_mem_ctl}, {60'd0, r_mem});
        chk("md_stall_cnt", {56'd0, md_stall_cnt}, 64'(r_cnt));
    endtask

    task automatic set_e(input bit v, input logic [3:0] t, input logic [31:0] alu,
                         input logic [4:0] wr);
        e_valid   = v;
        e_md_type = t;
        e_alu_res = alu;
        e_wr_addr = wr;
        e_pc      = alu ^ 32'h0000_1000;
        e_st_data = ~alu;
        e_mem_ctl = alu[3:0];
    endtask

    typedef struct {
        bit          rst;
        bit          valid;
        logic [3:0]  typ;
        logic [31:0] alu, hi, lo;
        bit          busy, flush, hold;
        logic [4:0]  wr;
        bit          x_stall;
        bit          x_valid;
        logic [31:0] x_res;
        logic [4:0]  x_wr;
        logic [7:0]  x_cnt;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{0, 1, 4'd5, 32'h11, 32'h22, 32'h33, 1, 0, 1, 5'd1, 0, 0, 32'h0, 5'd0, 8'd0};
        vecs[1] = '{1, 1, 4'd0, 32'h1234_5678, 32'h22, 32'h33, 0, 0, 0, 5'd8, 0, 1, 32'h1234_5678, 5'd8, 8'd0};
        vecs[2] = '{1, 1, 4'd5, 32'h44, 32'hAAAA_0001, 32'h33, 0, 0, 0, 5'd3, 0, 1, 32'hAAAA_0001, 5'd3, 8'd0};
        vecs[3] = '{1, 1, 4'd6, 32'h44, 32'h22, 32'hBBBB_0002, 0, 0, 0, 5'd4, 0, 1, 32'hBBBB_0002, 5'd4, 8'd0};
        vecs[4] = '{1, 1, 4'd0, 32'h55, 32'h22, 32'h33, 0, 1, 0, 5'd5, 0, 0, 32'h0, 5'd0, 8'd0};
        vecs[5] = '{1, 1, 4'd3, 32'h66, 32'h22, 32'h33, 1, 0, 0, 5'd6, 1, 0, 32'h0, 5'd0, 8'd1};
        vecs[6] = '{1, 1, 4'd0, 32'h77, 32'h22, 32'h33, 0, 0, 1, 5'd7, 1, 0, 32'h0, 5'd0, 8'd1};
        vecs[7] = '{1, 0, 4'd5, 32'h88, 32'h9, 32'h33, 1, 0, 0, 5'd2, 0, 0, 32'h9, 5'd2, 8'd1};
        vecs[8] = '{1, 1, 4'd0, 32'hDEAD, 32'h22, 32'h33, 0, 0, 0, 5'd1, 0, 1, 32'hDEAD, 5'd1, 8'd1};
        vecs[9] = '{1, 1, 4'd6, 32'h99, 32'h22, 32'h44, 1, 0, 1, 5'd9, 1, 1, 32'hDEAD, 5'd1, 8'd1};

        reset = 0; md_hi = 0; md_lo = 0; md_busy = 0; e_flush = 0; m_hold = 0;
        set_e(0, 4'd0, 32'h0, 5'd0);
        r_valid = 0; r_pc = 0; r_res = 0; r_st = 0; r_wr = 0; r_mem = 0; r_cnt = 0;

        // Directed table
        for (int i = 0; i < 10; i++) begin
            reset = vecs[i].rst; md_hi = vecs[i].hi; md_lo = vecs[i].lo;
            md_busy = vecs[i].busy; e_flush = vecs[i].flush; m_hold = vecs[i].hold;
            set_e(vecs[i].valid, vecs[i].typ, vecs[i].alu, vecs[i].wr);
            #1;
            chk($sformatf("vec%0d stall_req", i), {63'd0, stall_req}, {63'd0, vecs[i].x_stall});
            cycle();
            chk($sformatf("vec%0d m_valid", i), {63'd0, m_valid}, {63'd0, vecs[i].x_valid});
            chk($sformatf("vec%0d m_res", i), {32'd0, m_res}, {32'd0, vecs[i].x_res});
            chk($sformatf("vec%0d m_wr_addr", i), {59'd0, m_wr_addr}, {59'd0, vecs[i].x_wr});
            chk($sformatf("vec%0d cnt", i), {56'd0, md_stall_cnt}, {56'd0, vecs[i].x_cnt});
        end

        // Clean start for the multi-cycle sequences
        reset = 0; m_hold = 0; e_flush = 0; md_busy = 0;
        cycle();
        reset = 1;

        // mult issues (Busy still low), then mflo waits 5 Busy cycles
        set_e(1, 4'd3, 32'h0, 5'd0);
        cycle();
        set_e(1, 4'd6, 32'h5, 5'd9);
        md_busy = 1; md_lo = 32'h0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("mflo wait stall_req", {63'd0, stall_req}, 64'd1);
            cycle();
            chk("mflo bubble valid", {63'd0, m_valid}, 64'd0);
            chk("mflo bubble wr", {59'd0, m_wr_addr}, 64'd0);
        end
        md_busy = 0; md_lo = 32'hFFFF_FFF6;
        cycle();
        chk("mflo res", {32'd0, m_res}, 64'hFFFF_FFF6);
        chk("mflo valid", {63'd0, m_valid}, 64'd1);
        chk("mflo wr", {59'd0, m_wr_addr}, 64'd9);
        chk("mflo cnt", {56'd0, md_stall_cnt}, 64'd5);

        // div issues, mfhi waits 10 Busy cycles
        set_e(1, 4'd1, 32'h0, 5'd0);
        cycle();
        set_e(1, 4'd5, 32'h7, 5'd10);
        md_busy = 1; md_hi = 32'hBAD;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("mfhi bubble valid", {63'd0, m_valid}, 64'd0);
        end
        md_busy = 0; md_hi = 32'd3;
        cycle();
        chk("mfhi res", {32'd0, m_res}, 64'd3);
        chk("mfhi cnt", {56'd0, md_stall_cnt}, 64'd15);

        // Flush together with hazard: bubble, still counted
        set_e(1, 4'd5, 32'h8, 5'd11);
        md_busy = 1; e_flush = 1; md_hi = 32'hBAD;
        cycle();
        chk("flush+haz valid", {63'd0, m_valid}, 64'd0);
        chk("flush+haz wr", {59'd0, m_wr_addr}, 64'd0);
        chk("flush+haz cnt", {56'd0, md_stall_cnt}, 64'd16);
        e_flush = 0;

        // Load a real instruction, then hold 3 cycles while E changes under Busy
        md_busy = 0;
        set_e(1, 4'd0, 32'hCAFE_0001, 5'd12);
        cycle();
        md_busy = 1; m_hold = 1;
        for (int i = 0; i < 3; i++) begin
            set_e(1, 4'd6, 32'h100 + 32'(i), 5'd13);
            #1;
            chk("hold stall_req", {63'd0, stall_req}, 64'd1);
            cycle();
            chk("hold res", {32'd0, m_res}, 64'hCAFE_0001);
            chk("hold valid", {63'd0, m_valid}, 64'd1);
            chk("hold wr", {59'd0, m_wr_addr}, 64'd12);
            chk("hold cnt", {56'd0, md_stall_cnt}, 64'd16);
        end
        m_hold = 0;

        // Reset mid-hazard
        reset = 0;
        #1;
        chk("reset stall_req", {63'd0, stall_req}, 64'd0);
        cycle();
        chk("reset valid", {63'd0, m_valid}, 64'd0);
        chk("reset res", {32'd0, m_res}, 64'd0);
        chk("reset cnt", {56'd0, md_stall_cnt}, 64'd0);
        reset = 1;

        // Saturation: a long hazard drives the counter to all-ones and keeps it there
        for (int i = 0; i < CNT_MAX + 45; i++) cycle();
        chk("sat cnt", {56'd0, md_stall_cnt}, 64'hFF);
        cycle();
        chk("sat cnt stays", {56'd0, md_stall_cnt}, 64'hFF);

        // Constrained-random traffic against the model
        md_busy = 0;
        reset = 0;
        cycle();
        for (int i = 0; i < 3000; i++) begin
            reset   = ($urandom_range(0, 99) != 0);
            m_hold  = ($urandom_range(0, 4) == 0);
            e_flush = ($urandom_range(0, 9) == 0);
            md_busy = ($urandom_range(0, 2) == 0);
            md_hi   = $urandom;
            md_lo   = $urandom;
            e_valid   = ($urandom_range(0, 4) != 0);
            e_md_type = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 9));
            e_pc      = $urandom;
            e_alu_res = $urandom;
            e_st_data = $urandom;
            e_wr_addr = 5'($urandom);
            e_mem_ctl = 4'($urandom);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
